cam_frame_writer: RTL
=====================

Name: cam_frame_writer

Overview:
- Write-side initiator for buffer_ram_dp: converts a pre-synchronised OV7670-style byte stream (vsync/href/byte strobe) into RGB565 words and drives the RAM write port (addr_in, data_in, regwrite).
- Captures one frame of IMG_W x IMG_H pixels per request into the frame buffer; the display/readout logic uses the read port.
- All camera inputs are already synchronised to clk upstream; this block has one clock domain.

Parameters:
IMG_W, 160, active pixels stored per line
IMG_H, 120, lines stored per frame
AW, 15, RAM address width (IMG_W*IMG_H must be <= 2**AW)
DW, 16, RAM data width (RGB565)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request: capture the next full frame
cam_vsync  in  1  frame sync, high between frames
cam_href  in  1  line valid, high while a line's bytes arrive
cam_byte_valid  in  1  one-cycle strobe: cam_data holds a new byte
cam_data  in  8  camera byte
addr_in  out  AW  RAM write address
data_in  out  DW  RAM write data {first byte, second byte}
regwrite  out  1  RAM write enable, one-cycle pulse per pixel
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse when capture ends
pix_count  out  AW+1  pixels written in last/current frame

Behaviour:
- Reset: addr_in=0, data_in=0, regwrite=0, busy=0, frame_done=0, pix_count=0, state=IDLE, byte phase=0, col=0, line=0. Reset mid-capture aborts immediately; no further writes, no frame_done.
- States: IDLE -> WAIT_VS_HI -> WAIT_VS_LO -> CAPTURE -> DONE -> IDLE.
- IDLE: start=1 -> WAIT_VS_HI, busy=1, pix_count=0, addr=0. start ignored in every other state.
- WAIT_VS_HI: wait cam_vsync=1 (guarantees capture begins on a frame boundary, never mid-frame). WAIT_VS_LO: cam_vsync=0 -> CAPTURE.
- CAPTURE: byte accepted iff cam_byte_valid=1 and cam_href=1. Phase 0: latch high byte. Phase 1: form pixel {hi,lo}. If col<IMG_W and line<IMG_H: next cycle regwrite=1, data_in={hi,lo}, addr_in=current address; address and pix_count increment the cycle after the pulse. Otherwise pixel discarded, no write. col increments per pixel (saturating at IMG_W).
- Write latency: exactly 1 cycle from second-byte strobe to regwrite pulse. Back-to-back byte strobes every cycle are supported (a write every 2 cycles max).
- href falling edge (registered href_d=1, href=0): if col>0, line increments; col=0; byte phase=0 (a dangling odd byte is dropped).
- Frame end: line reaches IMG_H, or cam_vsync rises while in CAPTURE (truncated frame) -> DONE. A write pending in the same cycle still completes.
- DONE: frame_done=1 for one cycle, busy=0, -> IDLE. pix_count holds final value until next accepted start.
- addr_in never exceeds IMG_W*IMG_H-1; no wrap-around within a frame. regwrite=0 in every state except the pulse cycle in CAPTURE.
- data_in holds last written value between pulses.

Test Plan:
- Reset: assert rst 3 cycles mid-stream -> all outputs 0, state IDLE; no regwrite for 20 cycles after with stream running and start=0.
- Single pixel: start, vsync 1->0, href=1, bytes 0xF8 then 0x1F -> one cycle later regwrite=1, addr_in=0, data_in=0xF81F; next pixel lands at addr_in=1.
- Full frame IMG_W=4, IMG_H=2, lines of 6 pixels each with incrementing data -> exactly 8 writes, addresses 0..7, pixels 5-6 of each line dropped, frame_done one pulse, pix_count=8, busy low after.
- Start mid-frame (vsync=0, href toggling) -> zero writes until vsync high then low; first write addr 0 holds first pixel of new frame.
- Odd byte: line with 3 bytes then href falls -> one write; next line's first byte is treated as high byte.
- Truncated frame: vsync rises after 5 of 8 pixels -> frame_done pulse, pix_count=5, no further writes; start during busy ignored.

Source files
------------

// File: rtl/cam_frame_writer.sv
// Camera capture front end: packs OV7670-style byte pairs into RGB565 pixels and
// writes one IMG_W x IMG_H frame per start request into the frame-buffer write port.
module cam_frame_writer #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int AW    = 15,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic          cam_byte_valid,
    input  logic [7:0]    cam_data,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite,
    output logic          busy,
    output logic          frame_done,
    output logic [AW:0]   pix_count
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int LW = $clog2(IMG_H + 1);
    localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W);
    localparam logic [LW-1:0] LINE_MAX  = LW'(IMG_H);
    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS_HI,
        WAIT_VS_LO,
        CAPTURE,
        DONE
    } state_t;

    state_t        state, state_next;
    logic          phase;
    logic [7:0]    hi_byte;
    logic [CW-1:0] col;
    logic [LW-1:0] line;
    logic          href_d;
    logic          start_ok;
    logic          frame_end;
    logic          byte_ok;
    logic          href_fall;
    logic          pixel_ok;

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        frame_end  = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WAIT_VS_HI;
                    start_ok   = 1'b1;
                end
            end
            WAIT_VS_HI: begin
                busy = 1'b1;
                if (cam_vsync) state_next = WAIT_VS_LO;
            end
            WAIT_VS_LO: begin
                busy = 1'b1;
                if (!cam_vsync) state_next = CAPTURE;
            end
            CAPTURE: begin
                busy = 1'b1;
                // vsync high inside CAPTURE can only be a rising edge: truncated frame
                if (cam_vsync || line == LINE_MAX) begin
                    frame_end  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bytes and line ends are only honoured while the frame is still open, so a
    // write pulse can only ever land in a CAPTURE cycle.
    assign byte_ok   = (state == CAPTURE) && !frame_end && cam_href && cam_byte_valid;
    assign href_fall = (state == CAPTURE) && !frame_end && href_d && !cam_href;
    assign pixel_ok  = byte_ok && phase && (col < COL_MAX) && (line < LINE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_in   <= '0;
            data_in   <= '0;
            regwrite  <= 1'b0;
            pix_count <= '0;
            phase     <= 1'b0;
            hi_byte   <= '0;
            col       <= '0;
            line      <= '0;
            href_d    <= 1'b0;
        end else begin
            state    <= state_next;
            href_d   <= cam_href;
            regwrite <= pixel_ok;
            if (pixel_ok) data_in <= DW'({hi_byte, cam_data});

            // Address/count advance in the cycle after the pulse; address clamps at the last cell.
            if (start_ok) begin
                addr_in   <= '0;
                pix_count <= '0;
                phase     <= 1'b0;
                col       <= '0;
                line      <= '0;
            end else if (regwrite) begin
                pix_count <= pix_count + (AW + 1)'(1);
                if (addr_in != LAST_ADDR) addr_in <= addr_in + AW'(1);
            end

            if (byte_ok) begin
                if (!phase) begin
                    hi_byte <= cam_data;
                    phase   <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (col < COL_MAX) col <= col + CW'(1);
                end
            end else if (href_fall) begin
                if (col != '0) line <= line + LW'(1);
                col   <= '0;
                phase <= 1'b0;
            end
        end
    end

endmodule
